// File: rtl/fetch_interrupt_sequencer_if.sv
// Bundle between the fetch interrupt sequencer and the fetch/execute side.
//   i_irq                : external interrupt request (level, rising edge is the event)
//   i_hazard_instruction : fetch sees a control-hazard opcode at the current PC
//   i_branch_decision    : PC is redirected to a new target this cycle
//   i_stall              : downstream stall request
//   o_fetch_enable       : PC register enable for the fetch stage
//   o_interrupt_signal   : interrupt inject (NOP injection, PC hold/redirect)
//   o_busy               : sequencer is not idle
//   o_irq_coalesced      : one-cycle pulse, an irq edge merged into a pending one
// slave is the sequencer side, master is the fetch/execute (or bench) side.
interface fetch_interrupt_sequencer_if;
  logic i_irq;
  logic i_hazard_instruction;
  logic i_branch_decision;
  logic i_stall;
  logic o_fetch_enable;
  logic o_interrupt_signal;
  logic o_busy;
  logic o_irq_coalesced;

  modport slave (
    input  i_irq,
    input  i_hazard_instruction,
    input  i_branch_decision,
    input  i_stall,
    output o_fetch_enable,
    output o_interrupt_signal,
    output o_busy,
    output o_irq_coalesced
  );

  modport master (
    output i_irq,
    output i_hazard_instruction,
    output i_branch_decision,
    output i_stall,
    input  o_fetch_enable,
    input  o_interrupt_signal,
    input  o_busy,
    input  o_irq_coalesced
  );
endinterface

// File: rtl/fetch_interrupt_sequencer.sv
// Sequences the fetch stage around interrupts and control hazards.
// An irq edge is latched, held until no control-hazard instruction is in
// flight, then injected for INT_CYCLES cycles; fetch is then frozen until the
// vector/branch target resolves.
// Ports:
//   i_clk   : rising-edge clock
//   i_reset : asynchronous active-high reset
//   bus     : fetch_interrupt_sequencer_if.slave (irq/hazard/branch/stall in,
//             fetch_enable/interrupt_signal/busy/irq_coalesced out)
module fetch_interrupt_sequencer #(
  parameter int HAZ_WINDOW = 3,
  parameter int INT_CYCLES = 2,
  parameter int CNT_W      = 3
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  fetch_interrupt_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    INJECT  = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HAZ_LOAD = CNT_W'(HAZ_WINDOW);
  localparam logic [CNT_W-1:0] INT_LOAD = CNT_W'(INT_CYCLES - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic             irq_prev_r;
  logic             irq_pending_r;
  logic             coalesced_r;
  logic [CNT_W-1:0] haz_cnt_r;
  logic [CNT_W-1:0] int_cnt_r;

  logic             irq_rise_s;
  logic             coalesce_s;
  logic             haz_load_s;
  logic             fire_s;
  logic             fetch_enable_s;
  logic             fetch_en_gated_s;
  logic             interrupt_s;
  logic             busy_s;

  assign irq_rise_s = bus.i_irq & ~irq_prev_r;
  // An edge arriving while one is already being handled is merged into it
  // and must not re-arm irq_pending.
  assign coalesce_s = irq_rise_s & (irq_pending_r | (state_r != IDLE));
  // PC enable is forced low while reset is held, independent of state.
  assign fetch_en_gated_s = fetch_enable_s & ~i_reset;
  assign haz_load_s = bus.i_hazard_instruction & fetch_en_gated_s;
  // Inject only once no hazard is in flight, none is being fetched now,
  // nothing stalls and no redirect happens this cycle.
  assign fire_s = (state_r == PENDING) && (haz_cnt_r == CNT_ZERO) &&
                  !bus.i_stall && !bus.i_branch_decision && !haz_load_s;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (irq_pending_r) state_next_s = PENDING;
        else               state_next_s = IDLE;
      end
      PENDING: begin
        if (fire_s) state_next_s = INJECT;
        else        state_next_s = PENDING;
      end
      INJECT: begin
        if (int_cnt_r == CNT_ZERO) state_next_s = DRAIN;
        else                       state_next_s = INJECT;
      end
      DRAIN: begin
        if (bus.i_branch_decision) state_next_s = IDLE;
        else                       state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: inject/busy from state only, fetch enable also from inputs
  always_comb begin
    fetch_enable_s = 1'b0;
    interrupt_s    = 1'b0;
    busy_s         = 1'b0;
    case (state_r)
      IDLE: begin
        fetch_enable_s = ~bus.i_stall;
      end
      PENDING: begin
        fetch_enable_s = ~bus.i_stall;
        busy_s         = 1'b1;
      end
      INJECT: begin
        fetch_enable_s = 1'b1;
        interrupt_s    = 1'b1;
        busy_s         = 1'b1;
      end
      DRAIN: begin
        fetch_enable_s = bus.i_branch_decision;
        busy_s         = 1'b1;
      end
      default: begin
        fetch_enable_s = 1'b0;
        interrupt_s    = 1'b0;
        busy_s         = 1'b0;
      end
    endcase
  end

  // Edge detect, pending latch, coalesce pulse, hazard and inject counters
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      irq_prev_r    <= 1'b0;
      irq_pending_r <= 1'b0;
      coalesced_r   <= 1'b0;
      haz_cnt_r     <= CNT_ZERO;
      int_cnt_r     <= CNT_ZERO;
    end else begin
      irq_prev_r  <= bus.i_irq;
      coalesced_r <= coalesce_s;

      // A fresh edge wins over the clear issued when injection starts.
      if (irq_rise_s && !coalesce_s) irq_pending_r <= 1'b1;
      else if (fire_s)               irq_pending_r <= 1'b0;
      else                           irq_pending_r <= irq_pending_r;

      // A newly fetched hazard wins over a same-cycle branch resolution.
      if (haz_load_s)                   haz_cnt_r <= HAZ_LOAD;
      else if (bus.i_branch_decision)   haz_cnt_r <= CNT_ZERO;
      else if (haz_cnt_r != CNT_ZERO)   haz_cnt_r <= haz_cnt_r - CNT_ONE;
      else                              haz_cnt_r <= haz_cnt_r;

      if (fire_s)
        int_cnt_r <= INT_LOAD;
      else if ((state_r == INJECT) && (int_cnt_r != CNT_ZERO))
        int_cnt_r <= int_cnt_r - CNT_ONE;
      else
        int_cnt_r <= int_cnt_r;
    end
  end

  assign bus.o_fetch_enable     = fetch_en_gated_s;
  assign bus.o_interrupt_signal = interrupt_s;
  assign bus.o_busy             = busy_s;
  assign bus.o_irq_coalesced    = coalesced_r;

endmodule

// File: tb/tb_fetch_interrupt_sequencer.sv
// Randomized bench for fetch_interrupt_sequencer against a timestamp-based
// reference model of the sequencing rules.
module tb_fetch_interrupt_sequencer;

  localparam int HAZ_WINDOW = 3;
  localparam int INT_CYCLES = 2;
  localparam int N_CYCLES   = 4000;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_interrupt_sequencer_if bus ();

  fetch_interrupt_sequencer #(
    .HAZ_WINDOW (HAZ_WINDOW),
    .INT_CYCLES (INT_CYCLES),
    .CNT_W      (3)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an interrupt moves latched -> waiting -> injecting
  // (counted in remaining cycles) -> draining. The hazard window is tracked
  // as the cycle number of the last hazard fetch plus a "resolved" flag.
  int m_pending, m_waiting, m_inject_left, m_drain, m_prev, m_coal;
  int last_load, resolved, cyc;
  int inj_reset_done;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_waiting = 0; m_inject_left = 0; m_drain = 0;
    m_prev = 0; m_coal = 0; last_load = -1000; resolved = 0;
  endtask

  function automatic int model_fe(input int st, input int br);
    if (m_inject_left > 0) return 1;
    if (m_drain != 0)      return br;
    return (st != 0) ? 0 : 1;
  endfunction

  task automatic model_step(input int irq, input int haz, input int br, input int st);
    int fe, busy, rise, coal, clear, fire;
    fe    = model_fe(st, br);
    busy  = (m_waiting != 0 || m_inject_left > 0 || m_drain != 0) ? 1 : 0;
    rise  = (irq != 0 && m_prev == 0) ? 1 : 0;
    coal  = (rise != 0 && (m_pending != 0 || busy != 0)) ? 1 : 0;
    clear = ((cyc - last_load) > HAZ_WINDOW || resolved != 0) ? 1 : 0;
    fire  = (m_waiting != 0 && clear != 0 && st == 0 && br == 0 &&
             !(haz != 0 && fe != 0)) ? 1 : 0;
    if (m_drain != 0) begin
      if (br != 0) m_drain = 0;
    end else if (m_inject_left > 0) begin
      m_inject_left--;
      if (m_inject_left == 0) m_drain = 1;
    end else if (m_waiting != 0) begin
      if (fire != 0) begin
        m_waiting = 0;
        m_inject_left = INT_CYCLES;
      end
    end else if (m_pending != 0) begin
      m_waiting = 1;
    end
    if (rise != 0 && coal == 0) m_pending = 1;
    else if (fire != 0)         m_pending = 0;
    if (haz != 0 && fe != 0) begin
      last_load = cyc;
      resolved  = 0;
    end else if (br != 0) begin
      resolved = 1;
    end
    m_prev = irq;
    m_coal = coal;
  endtask

  // Called #1 after a rising edge: drive inputs, check outputs, advance model.
  task automatic normal_cycle();
    int irq, haz, br, st;
    irq = int'(bus.i_irq);
    if ($urandom_range(0, 5) == 0) irq = (irq != 0) ? 0 : 1;
    haz = ($urandom_range(0, 4) == 0) ? 1 : 0;
    if (m_drain != 0) br = ($urandom_range(0, 2) == 0) ? 1 : 0;
    else              br = ($urandom_range(0, 7) == 0) ? 1 : 0;
    st = ($urandom_range(0, 4) == 0) ? 1 : 0;
    bus.i_irq                = irq[0];
    bus.i_hazard_instruction = haz[0];
    bus.i_branch_decision    = br[0];
    bus.i_stall              = st[0];
    #3;
    check_val("fetch_enable", 32'(bus.o_fetch_enable), 32'(model_fe(st, br)));
    check_val("interrupt",    32'(bus.o_interrupt_signal), (m_inject_left > 0) ? 32'd1 : 32'd0);
    check_val("busy",         32'(bus.o_busy),
              (m_waiting != 0 || m_inject_left > 0 || m_drain != 0) ? 32'd1 : 32'd0);
    check_val("coalesced",    32'(bus.o_irq_coalesced), 32'(m_coal));
    model_step(irq, haz, br, st);
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic do_reset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    check_val({tag, "_fe"},   32'(bus.o_fetch_enable), 32'd0);
    check_val({tag, "_int"},  32'(bus.o_interrupt_signal), 32'd0);
    check_val({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check_val({tag, "_coal"}, 32'(bus.o_irq_coalesced), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_val({tag, "_hold_int"}, 32'(bus.o_interrupt_signal), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    inj_reset_done = 0;
    model_reset();
    rst = 1'b1;
    bus.i_irq                = 1'b0;
    bus.i_hazard_instruction = 1'b0;
    bus.i_branch_decision    = 1'b0;
    bus.i_stall              = 1'b0;
    @(posedge clk);
    #1;
    check_val("por_fe",   32'(bus.o_fetch_enable), 32'd0);
    check_val("por_busy", 32'(bus.o_busy), 32'd0);
    check_val("por_int",  32'(bus.o_interrupt_signal), 32'd0);
    check_val("por_coal", 32'(bus.o_irq_coalesced), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N_CYCLES; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i >= 2000 && inj_reset_done == 0 && m_inject_left > 0) begin
        do_reset("inj_rst");
        inj_reset_done = 1;
      end else if ((i % 900) == 450) begin
        do_reset("mid_rst");
      end
      normal_cycle();
    end
    check_val("inj_reset_seen", 32'(inj_reset_done), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
